mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/cpu_types_pkg.sv | 60 ++++++
 rtl/mul_sequencer_if.sv | 32 +++
 rtl/mul_sequencer_partial.sv | 15 +
 rtl/mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_mul_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the iterative multiplier: operation encoding,
// iteration limit, sequencer state and small decode helpers.
// The optional early-termination feature is selected with MUL_EARLY_TERM_EN.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MLA   = 3'd1,
    OP_UMULL = 3'd2,
    OP_UMLAL = 3'd3,
    OP_SMULL = 3'd4,
    OP_SMLAL = 3'd5
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  localparam int MUL_MAX_ITER = 4;

  // Long ops report 64 bits and flag on bit 63.
  function automatic logic op_is_long(mul_op_t op);
    return (op == OP_UMULL) || (op == OP_UMLAL) ||
           (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

  // Ops whose last multiplier byte carries a sign (everything but UMULL/UMLAL).
  function automatic logic op_signed_top(mul_op_t op);
    return !((op == OP_UMULL) || (op == OP_UMLAL));
  endfunction

  // Only the signed long ops treat rm as a two's-complement value.
  function automatic logic op_rm_signed(mul_op_t op);
    return (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

  // Starting accumulator value for each op.
  function automatic logic [63:0] acc_init(mul_op_t op, logic [31:0] lo, logic [31:0] hi);
    logic [63:0] v;
    v = 64'd0;
    if (op == OP_UMLAL || op == OP_SMLAL) v = {hi, lo};
    else if (op == OP_MLA)                v = {32'd0, lo};
    return v;
  endfunction

  // Early-termination iteration count: stop once the remaining upper bytes
  // are all zeros (or all ones when the top byte is signed).
  function automatic logic [2:0] early_iters(logic [31:0] rs, logic sx);
    logic [2:0] m;
    if      (rs[31:8]  == 24'd0 || (sx && (&rs[31:8])))  m = 3'd1;
    else if (rs[31:16] == 16'd0 || (sx && (&rs[31:16]))) m = 3'd2;
    else if (rs[31:24] == 8'd0  || (sx && (&rs[31:24]))) m = 3'd3;
    else                                                 m = 3'd4;
    return m;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/result bundle of the multiply sequencer.
// Handshake: a request transfers on a rising clk edge where start=1 and
// ready=1 (and abort=0); ready is high only while idle, start without ready
// is dropped; done is a single-cycle pulse with result/flags/iterations valid.
interface mul_sequencer_if;
  import cpu_types_pkg::*;

  logic        start;
  mul_op_t     op;
  logic [31:0] rm;
  logic [31:0] rs;
  logic [31:0] acc_lo;
  logic [31:0] acc_hi;
  logic        abort;
  logic        ready;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_n;
  logic        flag_z;
  logic [2:0]  iterations;

  modport master (
    output start, op, rm, rs, acc_lo, acc_hi, abort,
    input  ready, done, result_lo, result_hi, flag_n, flag_z, iterations
  );

  modport slave (
    input  start, op, rm, rs, acc_lo, acc_hi, abort,
    output ready, done, result_lo, result_hi, flag_n, flag_z, iterations
  );
endinterface

// File: rtl/mul_sequencer_partial.sv
// One partial product: 33-bit signed multiplicand times 9-bit signed
// multiplier byte, sign-extended to 64 bits. Purely combinational.
module mul_partial (
  input  logic signed [32:0] a_i,
  input  logic signed [8:0]  b_i,
  output logic        [63:0] p_o
);
  logic signed [41:0] prod;

  // Full-precision signed product, then sign extension.
  always_comb begin
    prod = a_i * b_i;
    p_o  = {{22{prod[41]}}, prod};
  end
endmodule

// File: rtl/mul_sequencer.sv
// Byte-serial multiply sequencer (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL).
// IDLE -> INIT -> ITER x m -> DONE; one rs byte is consumed per ITER.
// Define MUL_EARLY_TERM_EN to stop once the remaining rs bytes are
// redundant; otherwise m is always MUL_MAX_ITER.
module mul_sequencer
  import cpu_types_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mul_sequencer_if.slave   bus,
  output mul_state_t       dbg_state_o
);

  mul_state_t  state_q;
  mul_op_t     op_q;
  logic [31:0] rm_q;
  logic [31:0] rs_q;
  logic [63:0] init_q;
  logic [63:0] acc_q;
  logic [1:0]  k_q;
  logic [2:0]  m_q;
  logic        ready_q;
  logic        done_q;
  logic [31:0] res_lo_q;
  logic [31:0] res_hi_q;
  logic        n_q;
  logic        z_q;
  logic [2:0]  iter_q;

  logic        sx;
  logic        is_long;
  logic [2:0]  m_d;
  logic [5:0]  base;
  logic [32:0] rs_x;
  logic        last;
  logic [32:0] rm_ext;
  logic [8:0]  b_ext;
  logic [63:0] partial;
  logic [63:0] acc_d;

  assign sx      = op_signed_top(op_q);
  assign is_long = op_is_long(op_q);

`ifdef MUL_EARLY_TERM_EN
  assign m_d = early_iters(rs_q, sx);
`else
  assign m_d = 3'(MUL_MAX_ITER);
`endif

  // Select the current rs byte and build both partial-product operands.
  // The ninth bit of the last byte is the next rs bit up (rs[31] for the top
  // byte): with early termination the remaining bits are all equal, so this
  // is the sign of the whole remaining value and keeps results identical to
  // the full four-iteration sequence.
  always_comb begin
    base   = {1'b0, k_q, 3'b000};
    rs_x   = {rs_q[31], rs_q};
    last   = ({1'b0, k_q} == (m_q - 3'd1));
    rm_ext = {op_rm_signed(op_q) & rm_q[31], rm_q};
    b_ext  = {(sx && last) ? rs_x[base + 6'd8] : 1'b0, rs_x[base +: 8]};
    acc_d  = acc_q + (partial << base);
  end

  mul_partial u_partial (
    .a_i (rm_ext),
    .b_i (b_ext),
    .p_o (partial)
  );

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      rm_q     <= 32'd0;
      rs_q     <= 32'd0;
      init_q   <= 64'd0;
      acc_q    <= 64'd0;
      k_q      <= 2'd0;
      m_q      <= 3'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      iter_q   <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            op_q    <= bus.op;
            rm_q    <= bus.rm;
            rs_q    <= bus.rs;
            init_q  <= acc_init(bus.op, bus.acc_lo, bus.acc_hi);
            ready_q <= 1'b0;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (bus.abort) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            acc_q   <= init_q;
            m_q     <= m_d;
            k_q     <= 2'd0;
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (bus.abort) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            if (last) begin
              done_q   <= 1'b1;
              res_lo_q <= acc_d[31:0];
              res_hi_q <= is_long ? acc_d[63:32] : 32'd0;
              n_q      <= is_long ? acc_d[63] : acc_d[31];
              z_q      <= is_long ? (acc_d == 64'd0) : (acc_d[31:0] == 32'd0);
              iter_q   <= m_q;
              state_q  <= ST_DONE;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // An abort arriving in the DONE cycle suppresses that cycle's pulse.
  assign bus.done       = done_q & ~bus.abort;
  assign bus.ready      = ready_q;
  assign bus.result_lo  = res_lo_q;
  assign bus.result_hi  = res_hi_q;
  assign bus.flag_n     = n_q;
  assign bus.flag_z     = z_q;
  assign bus.iterations = iter_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: hand-computed products, latency,
// abort/reset behaviour, and the busy-start drop.
module tb_mul_sequencer;
  import cpu_types_pkg::*;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  mul_state_t dbg_state;

  always #5 clk = ~clk;

  mul_sequencer_if bus_if ();

  mul_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    bus_if.op     = OP_MUL;
    bus_if.rm     = 32'd0;
    bus_if.rs     = 32'd0;
    bus_if.acc_lo = 32'd0;
    bus_if.acc_hi = 32'd0;
  endtask

  // Presents a request for one cycle; returns 1ns after the accepting edge.
  task automatic issue(input mul_op_t op, input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] alo, input logic [31:0] ahi);
    @(negedge clk);
    bus_if.op     = op;
    bus_if.rm     = rm;
    bus_if.rs     = rs;
    bus_if.acc_lo = alo;
    bus_if.acc_hi = ahi;
    bus_if.start  = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
  endtask

  // Runs one op and checks latency, result, flags and iteration count.
  // With poke set, a conflicting start is driven while the op is busy.
  task automatic run_op(input string tag, input mul_op_t op,
                        input logic [31:0] rm, input logic [31:0] rs,
                        input logic [31:0] alo, input logic [31:0] ahi,
                        input logic [63:0] exp_res, input int m_et, input bit poke);
    int          m_exp;
    int          lat;
    bit          long_op;
    logic [63:0] exp;
    m_exp   = ET ? m_et : 4;
    lat     = 0;
    long_op = (op == OP_UMULL) || (op == OP_UMLAL) || (op == OP_SMULL) || (op == OP_SMLAL);
    exp_q.push_back(exp_res);
    issue(op, rm, rs, alo, ahi);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (poke && c == 2) begin
        bus_if.op = OP_MUL;
        bus_if.rm = 32'hFFFF_FFFF;
        bus_if.rs = 32'h7777_7777;
        bus_if.start = 1'b1;
      end
      if (c == 3) bus_if.start = 1'b0;
      if (bus_if.done) begin
        lat = c;
        break;
      end
    end
    bus_if.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(m_exp + 2));
    check({tag, " result_lo"}, 64'(bus_if.result_lo), 64'(exp[31:0]));
    check({tag, " result_hi"}, 64'(bus_if.result_hi), long_op ? 64'(exp[63:32]) : 64'd0);
    check({tag, " flag_n"}, 64'(bus_if.flag_n), long_op ? 64'(exp[63]) : 64'(exp[31]));
    check({tag, " flag_z"}, 64'(bus_if.flag_z),
          long_op ? 64'(exp == 64'd0) : 64'(exp[31:0] == 32'd0));
    check({tag, " iterations"}, 64'(bus_if.iterations), 64'(m_exp));
    @(negedge clk);
    check({tag, " done pulse width"}, 64'(bus_if.done), 64'd0);
    check({tag, " ready after"}, 64'(bus_if.ready), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int m_exp;
    bit seen;
    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset ready", 64'(bus_if.ready), 64'd1);
    check("reset done", 64'(bus_if.done), 64'd0);
    check("reset result_lo", 64'(bus_if.result_lo), 64'd0);
    check("reset result_hi", 64'(bus_if.result_hi), 64'd0);
    check("reset flags", 64'({bus_if.flag_n, bus_if.flag_z}), 64'd0);
    check("reset iterations", 64'(bus_if.iterations), 64'd0);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));

    run_op("mul 3x5",      OP_MUL,   32'd3,         32'd5,         32'd0, 32'd0, 64'd15, 1, 1'b0);
    run_op("smull -1x-2",  OP_SMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 64'd2, 1, 1'b0);
    run_op("umull max",    OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
           64'hFFFF_FFFE_0000_0001, 4, 1'b0);
    run_op("umlal carry",  OP_UMLAL, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 64'h1_0000_0000, 1, 1'b0);
    run_op("mla zero",     OP_MLA,   32'd0, 32'd0, 32'd0, 32'd0, 64'd0, 1, 1'b0);
    run_op("smlal neg",    OP_SMLAL, 32'hFFFF_FFFE, 32'd3, 32'd1, 32'd0,
           64'hFFFF_FFFF_FFFF_FFFB, 1, 1'b0);
    run_op("mul wrap",     OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 64'd0, 3, 1'b0);
    run_op("mul 3x255",    OP_MUL,   32'd3, 32'h0000_00FF, 32'd0, 32'd0, 64'h2FD, 1, 1'b0);
    run_op("smull minmin", OP_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
           64'h4000_0000_0000_0000, 4, 1'b0);
    run_op("mla 7x-1+10",  OP_MLA,   32'd7, 32'hFFFF_FFFF, 32'd10, 32'd0, 64'd3, 1, 1'b0);
    run_op("umull busy start", OP_UMULL, 32'd3, 32'h1234_5678, 32'd0, 32'd0,
           64'h0000_0000_369D_0368, 4, 1'b1);

    // Abort during the second ITER cycle: no done, ready next cycle, results held.
    seen = 1'b0;
    issue(OP_UMULL, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort in iter state", 64'(dbg_state), 64'(ST_ITER));
    bus_if.abort = 1'b1;
    @(posedge clk);
    #1 bus_if.abort = 1'b0;
    @(negedge clk);
    check("abort ready next", 64'(bus_if.ready), 64'd1);
    for (int c = 0; c < 8; c++) begin
      if (bus_if.done) seen = 1'b1;
      @(negedge clk);
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort result held", 64'(bus_if.result_lo), 64'h369D_0368);

    // Abort and start together in IDLE: abort wins.
    seen = 1'b0;
    @(negedge clk);
    bus_if.op    = OP_MUL;
    bus_if.rm    = 32'd9;
    bus_if.rs    = 32'd9;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(posedge clk);
    #1 begin bus_if.start = 1'b0; bus_if.abort = 1'b0; end
    @(negedge clk);
    check("idle abort+start ready", 64'(bus_if.ready), 64'd1);
    check("idle abort+start state", 64'(dbg_state), 64'(ST_IDLE));
    for (int c = 0; c < 8; c++) begin
      if (bus_if.done) seen = 1'b1;
      @(negedge clk);
    end
    check("idle abort+start no done", 64'(seen), 64'd0);

    // Abort coinciding with the DONE cycle suppresses the pulse.
    m_exp = ET ? 1 : 4;
    issue(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd0);
    repeat (m_exp + 1) @(posedge clk);
    #1 bus_if.abort = 1'b1;
    @(negedge clk);
    check("done-abort state", 64'(dbg_state), 64'(ST_DONE));
    check("done-abort done", 64'(bus_if.done), 64'd0);
    @(posedge clk);
    #1 bus_if.abort = 1'b0;
    @(negedge clk);
    check("done-abort idle", 64'(bus_if.ready), 64'd1);

    // Reset mid-ITER returns everything to reset values.
    issue(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset state", 64'(dbg_state), 64'(ST_ITER));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid reset state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid reset ready", 64'(bus_if.ready), 64'd1);
    check("mid reset done", 64'(bus_if.done), 64'd0);
    check("mid reset result", 64'({bus_if.result_hi, bus_if.result_lo}), 64'd0);
    check("mid reset flags", 64'({bus_if.flag_n, bus_if.flag_z}), 64'd0);
    check("mid reset iterations", 64'(bus_if.iterations), 64'd0);
    run_op("mul 7x6", OP_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
